// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserialiser driven by the baud generator's 1/16-bit tick.
// Holds the last byte with data-available, framing and overrun status for the bus side.
module spart_rx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OS     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              brg_en,
   input  logic              rxd,
   input  logic              rd_ack,
   output logic [DATA_W-1:0] rx_data,
   output logic              rda,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned TW = (OS > 1) ? $clog2(OS) : 1;
   localparam int unsigned BW = $clog2(DATA_W + 1);

   localparam logic [TW-1:0] HalfLast = TW'(OS / 2 - 1);
   localparam logic [TW-1:0] BitLast  = TW'(OS - 1);
   localparam logic [BW-1:0] DataLast = BW'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rda_q, rda_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              rxd_m, rxd_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m   <= 1'b1;
         rxd_s   <= 1'b1;
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rda_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         rxd_m   <= rxd;
         rxd_s   <= rxd_m;
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rda_q   <= rda_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      rda_d   = rda_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      // A read acknowledge retires the byte; a coincident load below overrides rda.
      if (rd_ack) begin
         rda_d = 1'b0;
         ovr_d = 1'b0;
      end

      if (brg_en) begin
         case (state_q)
            StIdle: begin
               if (!rxd_s) begin
                  state_d = StStart;
                  tick_d  = '0;
               end
            end
            StStart: begin
               if (tick_q == HalfLast) begin
                  tick_d = '0;
                  if (rxd_s) begin
                     state_d = StIdle;
                  end else begin
                     bit_d   = '0;
                     state_d = StData;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            StData: begin
               if (tick_q == BitLast) begin
                  tick_d  = '0;
                  shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == DataLast) begin
                     state_d = StStop;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            StStop: begin
               if (tick_q == BitLast) begin
                  tick_d  = '0;
                  data_d  = shift_q;
                  ferr_d  = ~rxd_s;
                  rda_d   = 1'b1;
                  if (rda_q && !rd_ack) begin
                     ovr_d = 1'b1;
                  end
                  state_d = StIdle;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign rx_data   = data_q;
   assign rda       = rda_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed and random 8N1 frames against a byte-level receive model
// that predicts each stop-bit sample from the detected start tick.
module tb_spart_rx;

   localparam int DATA_W    = 8;
   localparam int OS        = 16;
   localparam int LoadTicks = OS / 2 + OS * (DATA_W + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              brg_en;
   logic              rxd;
   logic              rd_ack;
   logic [DATA_W-1:0] rx_data;
   logic              rda;
   logic              frame_err;
   logic              overrun;

   int errors = 0;
   int checks = 0;

   int period      = 4;
   int phase       = 0;
   int edge_no     = 0;
   int tick_no     = 0;
   int start_edge  = 0;
   int detect_tick = -1000;
   int rise_tick   = -1;
   int rise_count  = 0;
   bit want_detect = 1'b0;
   bit ack_on_load = 1'b0;
   logic rda_prev  = 1'b0;

   logic [DATA_W-1:0] exp_data = '0;
   logic              exp_rda  = 1'b0;
   logic              exp_ferr = 1'b0;
   logic              exp_ovr  = 1'b0;

   spart_rx #(
      .DATA_W (DATA_W),
      .OS     (OS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .brg_en    (brg_en),
      .rxd       (rxd),
      .rd_ack    (rd_ack),
      .rx_data   (rx_data),
      .rda       (rda),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
      check({tag, ".rda"}, 32'(rda), 32'(exp_rda));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
      check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
   endtask

   // One clk; inputs for the next edge are driven 1 time unit after this one.
   task automatic step();
      logic brg_at;
      brg_at = brg_en;
      @(posedge clk);
      #1;
      edge_no++;
      if (brg_at) tick_no++;
      // Two sync flops: the DUT first sees a low line on the third edge after it drops.
      if (want_detect && brg_at && edge_no >= start_edge + 3) begin
         detect_tick = tick_no;
         want_detect = 1'b0;
      end
      if (rda && !rda_prev) begin
         rise_count++;
         rise_tick = brg_at ? tick_no : -2;
      end
      rda_prev = rda;
      phase    = (phase + 1) % period;
      brg_en   = (phase == 0);
      rd_ack   = 1'b0;
      if (ack_on_load && brg_en && (tick_no + 1 == detect_tick + LoadTicks)) rd_ack = 1'b1;
   endtask

   task automatic model_load(input logic [DATA_W-1:0] b, input bit stop, input bit ack);
      if (exp_rda && !ack) exp_ovr = 1'b1;
      if (ack) exp_ovr = 1'b0;
      exp_rda  = 1'b1;
      exp_data = b;
      exp_ferr = ~stop;
   endtask

   task automatic do_ack(input string tag);
      rd_ack = 1'b1;
      step();
      exp_rda = 1'b0;
      exp_ovr = 1'b0;
      check_all(tag);
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] b, input bit stop, input bit ack_load,
                             input string tag);
      logic [DATA_W+1:0] frame;
      bit was_rda;
      frame       = {stop, b, 1'b0};
      was_rda     = exp_rda;
      rise_tick   = -1;
      ack_on_load = ack_load;
      for (int i = 0; i < DATA_W + 2; i++) begin
         rxd = frame[i];
         if (i == 0) begin
            start_edge  = edge_no;
            want_detect = 1'b1;
         end
         if (i == DATA_W + 1 && !stop) begin
            // Low only past the mid-bit sample, then idle high long enough to settle.
            repeat (OS * period / 2 + period + 4) step();
            rxd = 1'b1;
            repeat (OS * period * 3) step();
         end else begin
            repeat (OS * period) step();
         end
      end
      ack_on_load = 1'b0;
      model_load(b, stop, ack_load);
      check_all(tag);
      if (!was_rda && !ack_load)
         check({tag, ".rise_tick"}, 32'(rise_tick), 32'(detect_tick + LoadTicks));
   endtask

   initial begin
      logic [DATA_W-1:0] rb;
      bit                rs;
      int                rc;

      rst    = 1'b1;
      brg_en = 1'b0;
      rxd    = 1'b1;
      rd_ack = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check_all("reset");

      // Basic frame, brg_en every 4 clk.
      period = 4;
      send_frame(8'hA5, 1'b1, 1'b0, "a5");
      do_ack("a5_ack");

      // Glitch shorter than half a bit is rejected.
      rise_count = 0;
      rxd = 1'b0;
      repeat (5 * period) step();
      rxd = 1'b1;
      repeat (OS * period * 3) step();
      check_all("false_start");
      check("false_start.rises", 32'(rise_count), 32'd0);

      // Framing error, then a clean frame clears it.
      send_frame(8'h3C, 1'b0, 1'b0, "ferr");
      do_ack("ferr_ack");
      send_frame(8'h01, 1'b1, 1'b0, "ferr_next");
      do_ack("ferr_next_ack");

      // Two frames without acknowledge.
      send_frame(8'h11, 1'b1, 1'b0, "ovr_a");
      send_frame(8'h22, 1'b1, 1'b0, "ovr_b");
      do_ack("ovr_ack");

      // Acknowledge coincident with the second load.
      send_frame(8'h33, 1'b1, 1'b0, "coinc_a");
      rc = rise_count;
      send_frame(8'h7E, 1'b1, 1'b1, "coinc_b");
      check("coinc.rda_held", 32'(rise_count - rc), 32'd0);
      do_ack("coinc_ack");

      // Reset during data bit 4 of 0xFF discards the partial byte.
      rxd         = 1'b0;
      start_edge  = edge_no;
      want_detect = 1'b1;
      repeat (OS * period) step();
      rxd = 1'b1;
      repeat (OS * period * 4 + OS * period / 2) step();
      rst = 1'b1;
      step();
      rst        = 1'b0;
      rise_count = 0;
      exp_data   = '0;
      exp_rda    = 1'b0;
      exp_ferr   = 1'b0;
      exp_ovr    = 1'b0;
      check_all("mid_reset");
      repeat (OS * period * 6) step();
      check("mid_reset.rises", 32'(rise_count), 32'd0);
      send_frame(8'h55, 1'b1, 1'b0, "after_reset");
      check("after_reset.rises", 32'(rise_count), 32'd1);
      do_ack("after_reset_ack");

      // Random bytes, tick rates (period 1 = brg_en held high), stop bits and acks.
      for (int n = 0; n < 10; n++) begin
         period = $urandom_range(1, 4);
         rb     = DATA_W'($urandom);
         rs     = ($urandom_range(0, 3) != 0);
         send_frame(rb, rs, 1'b0, $sformatf("rnd%0d", n));
         if ($urandom_range(0, 2) != 0) do_ack($sformatf("rnd%0d_ack", n));
      end
      do_ack("final_ack");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
